// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio tone output stage.
package audio_pkg;
  localparam int CNT_W = 9;
  localparam int SMP_W = 16;

  localparam logic [CNT_W-1:0] LOAD_R = 9'd255;
  localparam logic [CNT_W-1:0] LOAD_L = 9'd511;

  typedef logic [SMP_W-1:0] sample_t;

  localparam sample_t AMP_BASE = 16'h0100;

  // vol 0 is silent; each step above 1 doubles the amplitude.
  function automatic sample_t vol_to_amp(input logic [2:0] vol);
    if (vol == 3'd0) return '0;
    return AMP_BASE << (vol - 3'd1);
  endfunction
endpackage

// File: rtl/audio_tone_out_if.sv
// Tone request inputs and DAC pin outputs of audio_tone_out.
interface audio_tone_out_if;
  logic [31:0] tone_freq;
  logic [2:0]  vol;
  logic        mute;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  logic        frame_tick;

  modport master (
    output tone_freq, vol, mute,
    input  audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_tick
  );

  modport slave (
    input  tone_freq, vol, mute,
    output audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_tick
  );
endinterface

// File: rtl/audio_tone_out_tone_square_gen.sv
// Phase accumulator square-wave generator; level toggles at 2*tone_freq per second.
module tone_square_gen #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned FREQ_MIN = 20,
  parameter int unsigned FREQ_MAX = 20_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] tone_freq,
  output logic        valid,
  output logic        level
);
  logic [31:0] acc_q, acc_d;
  logic        level_q, level_d;
  logic [32:0] sum;

  assign valid = (tone_freq >= FREQ_MIN) && (tone_freq <= FREQ_MAX);
  assign sum   = {1'b0, acc_q} + {tone_freq, 1'b0};
  assign level = level_q;

  // Out-of-range tones freeze the phase so the waveform resumes where it left off.
  always_comb begin
    acc_d   = acc_q;
    level_d = level_q;
    if (valid) begin
      if (sum >= 33'(CLK_HZ)) begin
        acc_d   = 32'(sum - 33'(CLK_HZ));
        level_d = ~level_q;
      end else begin
        acc_d = sum[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_q   <= '0;
      level_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/audio_tone_out.sv
// Square-tone PCM generator and left-justified I2S serializer for a CS4344-style DAC.
// Define AUDIO_TONE_FADE_EN to ramp the amplitude by AMP_STEP per frame.
module audio_tone_out
  import audio_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned FREQ_MIN = 20,
  parameter int unsigned FREQ_MAX = 20_000,
  parameter logic [15:0] AMP_STEP = 16'h0040
) (
  input  logic             clk,
  input  logic             reset,
  audio_tone_out_if.slave  bus
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sample_t          amp_q, amp_d;
  sample_t          sample_q, sample_d;
  sample_t          shift_q, shift_d;
  sample_t          target;
  logic             sq_valid, sq_level;
  logic             latch;

  tone_square_gen #(
    .CLK_HZ   (CLK_HZ),
    .FREQ_MIN (FREQ_MIN),
    .FREQ_MAX (FREQ_MAX)
  ) u_sq (
    .clk       (clk),
    .reset     (reset),
    .tone_freq (bus.tone_freq),
    .valid     (sq_valid),
    .level     (sq_level)
  );

  assign latch  = (cnt_q == LOAD_L);
  assign target = (bus.mute || !sq_valid) ? '0 : vol_to_amp(bus.vol);
  assign cnt_d  = cnt_q + 9'd1;

`ifdef AUDIO_TONE_FADE_EN
  // Step toward the target once per frame, landing exactly on it.
  always_comb begin
    amp_d = amp_q;
    if (latch) begin
      if (amp_q < target)
        amp_d = ((target - amp_q) > AMP_STEP) ? amp_q + AMP_STEP : target;
      else if (amp_q > target)
        amp_d = ((amp_q - target) > AMP_STEP) ? amp_q - AMP_STEP : target;
    end
  end
`else
  always_comb begin
    amp_d = amp_q;
    if (latch) amp_d = target;
  end

  // AMP_STEP only matters when fading.
  logic unused_step;
  assign unused_step = ^AMP_STEP;
`endif

  // Level is sampled before any toggle in the same cycle.
  always_comb begin
    sample_d = sample_q;
    if (latch) sample_d = sq_level ? amp_d : (~amp_d + 16'd1);
  end

  always_comb begin
    shift_d = shift_q;
    if (latch)
      shift_d = sample_d;
    else if (cnt_q == LOAD_R)
      shift_d = sample_q;
    else if (cnt_q[3:0] == 4'hF)
      shift_d = {shift_q[SMP_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q    <= '0;
      amp_q    <= '0;
      sample_q <= '0;
      shift_q  <= '0;
    end else begin
      cnt_q    <= cnt_d;
      amp_q    <= amp_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
    end
  end

  assign bus.audio_mclk = cnt_q[1];
  assign bus.audio_sck  = cnt_q[3];
  assign bus.audio_lrck = cnt_q[8];
  assign bus.audio_sdin = shift_q[SMP_W-1];
  assign bus.frame_tick = latch;
endmodule

// File: tb/tb_audio_tone_out.sv
// Randomized bench for audio_tone_out against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_audio_tone_out;
  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned FMIN   = 20;
  localparam int unsigned FMAX   = 20_000;
  localparam logic [15:0] STEP   = 16'h0040;

  logic clk = 1'b0;
  logic reset = 1'b0;
  audio_tone_out_if bus();

  audio_tone_out #(
    .CLK_HZ(CLK_HZ), .FREQ_MIN(FMIN), .FREQ_MAX(FMAX), .AMP_STEP(STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_mag(input string name, input logic [15:0] l, input logic [15:0] r,
                         input logic [15:0] mag);
    logic [15:0] neg;
    neg = 16'h0000 - mag;
    checks++;
    if (!((l == mag || l == neg) && r == l)) begin
      fails++;
      $display("FAIL %s: got left %h right %h expected +/-%h on both", name, l, r, mag);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] exp_amp(input logic [31:0] tf, input logic [2:0] v,
                                          input logic m);
    if (m || tf < FMIN || tf > FMAX || v == 3'd0) return 16'h0000;
    return 16'(256 * (1 << (v - 1)));
  endfunction

  int unsigned pos;
  longint      acc_m;
  bit          lvl_m, old_lvl;
  logic [15:0] word_m, amp_m, tgt_m;
  bit          started = 0;
  longint      s_m;

  always @(posedge clk) begin
    started = 1;
    if (!reset) begin
      pos = 0; acc_m = 0; lvl_m = 0; word_m = 0; amp_m = 0;
    end else begin
      tgt_m   = exp_amp(bus.tone_freq, bus.vol, bus.mute);
      old_lvl = lvl_m;
      if (bus.tone_freq >= FMIN && bus.tone_freq <= FMAX) begin
        s_m = acc_m + 2 * longint'(bus.tone_freq);
        if (s_m >= CLK_HZ) begin
          acc_m = s_m - CLK_HZ;
          lvl_m = !lvl_m;
        end else acc_m = s_m;
      end
      if (pos == 511) begin
`ifdef AUDIO_TONE_FADE_EN
        if (amp_m < tgt_m) amp_m = (tgt_m - amp_m > STEP) ? amp_m + STEP : tgt_m;
        else if (amp_m > tgt_m) amp_m = (amp_m - tgt_m > STEP) ? amp_m - STEP : tgt_m;
`else
        amp_m = tgt_m;
`endif
        word_m = old_lvl ? amp_m : 16'h0000 - amp_m;
      end
      pos = (pos + 1) % 512;
    end
  end

  // Every cycle: clocks come from frame position, data from the current word's bit slot.
  always @(negedge clk) begin
    if (started) begin
      chk("mclk", bus.audio_mclk, pos[1]);
      chk("sck",  bus.audio_sck,  pos[3]);
      chk("lrck", bus.audio_lrck, pos[8]);
      chk("frame_tick", bus.frame_tick, pos == 511);
      chk("sdin", bus.audio_sdin, word_m[15 - (pos % 256) / 16]);
    end
  end

  // Square half-period at 440 Hz with a 1 MHz clock: 1e6/880 = 1136.36 cycles.
  bit   meas_en = 0;
  int   last_t = -1;
  int   cyc = 0;
  logic prev_lvl = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (meas_en && dut.sq_level !== prev_lvl) begin
      if (last_t >= 0) begin
        checks++;
        if (!((cyc - last_t) == 1136 || (cyc - last_t) == 1137)) begin
          fails++;
          $display("FAIL lvl_period: got %0d expected 1136 or 1137", cyc - last_t);
        end
      end
      last_t = cyc;
    end
    prev_lvl = dut.sq_level;
  end

  // Capture one frame's left/right words on SCK rising edges; call at a negedge.
  task automatic get_words(output logic [15:0] l, output logic [15:0] r);
    int   n = 0;
    int   guard = 0;
    logic prev;
    l = 16'h0; r = 16'h0;
    while (bus.frame_tick !== 1'b1 && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 600) begin
      checks++; fails++;
      $display("FAIL frame_tick_wait: got no tick expected one within 600 cycles");
    end
    prev = 1'b1;
    repeat (512) begin
      @(negedge clk);
      if (bus.audio_sck && !prev) begin
        if (n < 16) l = {l[14:0], bus.audio_sdin};
        else        r = {r[14:0], bus.audio_sdin};
        n++;
      end
      prev = bus.audio_sck;
    end
  endtask

  logic [15:0] wl, wr;
  logic [31:0] acc_snap;
  int          lr_k, ft_k;
  logic [15:0] mags [0:6] = '{16'h0100, 16'h0200, 16'h0400, 16'h0800,
                              16'h1000, 16'h2000, 16'h4000};

  initial begin
    bus.tone_freq = 32'd0; bus.vol = 3'd0; bus.mute = 1'b0;
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_mclk", bus.audio_mclk, 0);
    chk("rst_lrck", bus.audio_lrck, 0);
    chk("rst_sck",  bus.audio_sck,  0);
    chk("rst_sdin", bus.audio_sdin, 0);
    chk("rst_tick", bus.frame_tick, 0);

    bus.tone_freq = 32'd440; bus.vol = 3'd7;
    reset = 1'b1;
    last_t = -1; meas_en = 1;
    lr_k = -1; ft_k = -1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (bus.audio_lrck && lr_k < 0) lr_k = k;
      if (bus.frame_tick && ft_k < 0) ft_k = k;
      if (k == 100) begin
        chk("model_acc", acc_m, 64'd88000);
        chk("dut_acc", dut.u_sq.acc_q, 64'd88000);
      end
    end
    chk("first_lrck_rise", lr_k, 256);
    chk("first_frame_tick", ft_k, 511);
`ifdef AUDIO_TONE_FADE_EN
    chk("first_word", word_m, 16'hFFC0);
`else
    chk("first_word", word_m, 16'hC000);
    for (int i = 0; i < 6; i++) begin
      get_words(wl, wr);
      chk_mag("w440", wl, wr, 16'h4000);
    end
`endif
    meas_en = 0;

    // Out-of-range tones: silent, phase frozen.
    bus.tone_freq = 32'd10;
    get_words(wl, wr);
    acc_snap = dut.u_sq.acc_q;
    get_words(wl, wr);
    chk("acc_hold_10", dut.u_sq.acc_q, acc_snap);
`ifndef AUDIO_TONE_FADE_EN
    chk("word_10", {wl, wr}, 32'h0);
`endif
    bus.tone_freq = 32'd25_000;
    get_words(wl, wr);
    chk("acc_hold_25k", dut.u_sq.acc_q, acc_snap);
    get_words(wl, wr);
`ifndef AUDIO_TONE_FADE_EN
    chk("word_25k", {wl, wr}, 32'h0);
`endif

    bus.tone_freq = 32'd1000;
    for (int v = 1; v <= 7; v++) begin
      bus.vol = 3'(v);
      get_words(wl, wr);
      get_words(wl, wr);
`ifndef AUDIO_TONE_FADE_EN
      chk_mag($sformatf("vol%0d", v), wl, wr, mags[v-1]);
`endif
    end
    bus.mute = 1'b1;
    get_words(wl, wr);
`ifndef AUDIO_TONE_FADE_EN
    chk("mute_word", {wl, wr}, 32'h0);
`endif
    bus.mute = 1'b0;

    // Random segments including range edges and one mid-frame reset.
    for (int s = 0; s < 40; s++) begin
      case ($urandom_range(0, 5))
        0:       bus.tone_freq = $urandom_range(0, 30_000);
        1: begin
          case ($urandom_range(0, 3))
            0: bus.tone_freq = 32'd19;
            1: bus.tone_freq = 32'd20;
            2: bus.tone_freq = 32'd20_000;
            default: bus.tone_freq = 32'd20_001;
          endcase
        end
        default: bus.tone_freq = $urandom_range(20, 20_000);
      endcase
      bus.vol  = 3'($urandom_range(0, 7));
      bus.mute = ($urandom_range(0, 5) == 0);
      repeat ($urandom_range(50, 1500)) @(negedge clk);
      if (s == 20) begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
